// File: rtl/led_driver_multi.sv
// Multi-channel status-LED driver: per-channel off / on / blink / activity modes from one shared prescaler.
// Optional per-channel PWM brightness when LED_DRIVER_PWM_EN is defined (adds duty_i).

module led_driver_ch #(
    parameter int PRESC_W = 25,
    parameter int RATE_W  = 2,
    parameter int STRETCH = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [PRESC_W-1:0] c_i,
    input  logic               tick_i,
    input  logic [1:0]         mode_i,
    input  logic [RATE_W-1:0]  rate_i,
    input  logic               event_i,
`ifdef LED_DRIVER_PWM_EN
    input  logic [7:0]         duty_i,
`endif
    output logic               led_o,
    output logic               busy_o
);
    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_ON    = 2'b01;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [7:0] STR     = 8'(STRETCH);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               act, last, raw, gate, busy_raw;
    logic [PRESC_W-1:0] c_sh;

    assign act  = (mode_i == 2'b11);
    assign last = tick_i && (cnt_q == 8'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (!act) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // a pending event left over from the GAP->IDLE edge fires here
                    if (event_i || pend_q) begin
                        state_d = S_ON;
                        cnt_d   = STR;
                        pend_d  = 1'b0;
                    end
                end
                S_ON: begin
                    if (event_i) pend_d = 1'b1;
                    if (last) begin
                        state_d = S_GAP;
                        cnt_d   = STR;
                    end else if (tick_i) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_GAP: begin
                    if (event_i) pend_d = 1'b1;
                    if (last) begin
                        if (pend_q) begin
                            state_d = S_ON;
                            cnt_d   = STR;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end
                    end else if (tick_i) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    // shifting left by r brings c[PRESC_W-1-r] to the MSB
    assign c_sh = c_i << rate_i;

    always_comb begin
        case (mode_i)
            M_OFF:   raw = 1'b0;
            M_ON:    raw = 1'b1;
            M_BLINK: raw = c_sh[PRESC_W-1];
            default: raw = (state_q == S_ON);
        endcase
    end

`ifdef LED_DRIVER_PWM_EN
    assign gate = (duty_i == 8'hFF) || (c_i[7:0] < duty_i);
`else
    assign gate = 1'b1;
`endif

    assign busy_raw = act && (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            led_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            led_o   <= raw & gate;
            busy_o  <= busy_raw;
        end
    end
endmodule

module led_driver_multi #(
    parameter int NUM_CH  = 4,
    parameter int PRESC_W = 25,
    parameter int RATE_W  = 2,
    parameter int ACT_BIT = 20,
    parameter int STRETCH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [2*NUM_CH-1:0]      mode_i,
    input  logic [RATE_W*NUM_CH-1:0] rate_i,
    input  logic [NUM_CH-1:0]        event_i,
`ifdef LED_DRIVER_PWM_EN
    input  logic [8*NUM_CH-1:0]      duty_i,
`endif
    output logic [NUM_CH-1:0]        led_o,
    output logic [NUM_CH-1:0]        busy_o
);
    logic [PRESC_W-1:0] c_q;
    logic               tick;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) c_q <= '0;
        else            c_q <= c_q + 1'b1;
    end

    assign tick = &c_q[ACT_BIT-1:0];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        led_driver_ch #(
            .PRESC_W (PRESC_W),
            .RATE_W  (RATE_W),
            .STRETCH (STRETCH)
        ) u_ch (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .c_i       (c_q),
            .tick_i    (tick),
            .mode_i    (mode_i[2*k +: 2]),
            .rate_i    (rate_i[RATE_W*k +: RATE_W]),
            .event_i   (event_i[k]),
`ifdef LED_DRIVER_PWM_EN
            .duty_i    (duty_i[8*k +: 8]),
`endif
            .led_o     (led_o[k]),
            .busy_o    (busy_o[k])
        );
    end
endmodule

// File: tb/tb_led_driver_multi.sv
// Bench for led_driver_multi: timestamp-based activity model plus per-cycle compare and literal spot checks.
module tb_led_driver_multi;
    localparam int NUM_CH = 2, PRESC_W = 8, RATE_W = 2, ACT_BIT = 2, STRETCH = 3;
    localparam int CMAX = 1 << PRESC_W;
    localparam int TP   = 1 << ACT_BIT;

    logic                     clk_i = 1'b0;
    logic                     reset_n_i = 1'b0;
    logic [2*NUM_CH-1:0]      mode_i = '0;
    logic [RATE_W*NUM_CH-1:0] rate_i = '0;
    logic [NUM_CH-1:0]        event_i = '0;
`ifdef LED_DRIVER_PWM_EN
    logic [8*NUM_CH-1:0]      duty_i = '1;
`endif
    logic [NUM_CH-1:0]        led_o, busy_o;

    int tests = 0, fails = 0;

    always #5 clk_i = ~clk_i;

    led_driver_multi #(
        .NUM_CH(NUM_CH), .PRESC_W(PRESC_W), .RATE_W(RATE_W), .ACT_BIT(ACT_BIT), .STRETCH(STRETCH)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .mode_i    (mode_i),
        .rate_i    (rate_i),
        .event_i   (event_i),
`ifdef LED_DRIVER_PWM_EN
        .duty_i    (duty_i),
`endif
        .led_o     (led_o),
        .busy_o    (busy_o)
    );

    // Model: cycle index since reset release; an activity flash is a pair of end timestamps.
    int               cyc = 0;
    int               on_end [NUM_CH];
    int               gap_end[NUM_CH];
    bit               pend   [NUM_CH];
    logic [NUM_CH-1:0] exp_led = '0, exp_busy = '0;
    bit               chk_en = 0;

    // cycle index of the STRETCH-th tick at or after cycle t
    function automatic int nth_tick(int t);
        return t + (TP - 1 - (t % TP)) + (STRETCH - 1) * TP;
    endfunction

    always @(posedge clk_i) begin
        int c, m, r;
        bit on_now, gap_now, raw;
`ifdef LED_DRIVER_PWM_EN
        int d;
`endif
        if (!reset_n_i) begin
            cyc = 0;
            exp_led = '0;
            exp_busy = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                on_end[k] = -1; gap_end[k] = -1; pend[k] = 0;
            end
        end else begin
            c = cyc % CMAX;
            for (int k = 0; k < NUM_CH; k++) begin
                m = int'(mode_i[2*k +: 2]);
                r = int'(rate_i[RATE_W*k +: RATE_W]);
                on_now  = (cyc <= on_end[k]);
                gap_now = !on_now && (cyc <= gap_end[k]);
                case (m)
                    0:       raw = 0;
                    1:       raw = 1;
                    2:       raw = ((c >> (PRESC_W - 1 - r)) & 1) != 0;
                    default: raw = on_now;
                endcase
`ifdef LED_DRIVER_PWM_EN
                d = int'(duty_i[8*k +: 8]);
                if (!(d == 255 || (c % 256) < d)) raw = 0;
`endif
                exp_led[k]  = raw;
                exp_busy[k] = (m == 3) && (on_now || gap_now);
                if (m != 3) begin
                    on_end[k] = -1; gap_end[k] = -1; pend[k] = 0;
                end else if (!on_now && !gap_now) begin
                    if (event_i[k] || pend[k]) begin
                        on_end[k]  = nth_tick(cyc + 1);
                        gap_end[k] = nth_tick(on_end[k] + 1);
                        pend[k]    = 0;
                    end
                end else if (gap_now && cyc == gap_end[k] && pend[k]) begin
                    on_end[k]  = nth_tick(cyc + 1);
                    gap_end[k] = nth_tick(on_end[k] + 1);
                    pend[k]    = 0;
                end else if (event_i[k]) begin
                    pend[k] = 1;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            tests++;
            if (led_o !== exp_led) begin
                fails++;
                $display("FAIL led_o cyc=%0d: got %b, required %b", cyc, led_o, exp_led);
            end
            tests++;
            if (busy_o !== exp_busy) begin
                fails++;
                $display("FAIL busy_o cyc=%0d: got %b, required %b", cyc, busy_o, exp_busy);
            end
        end
    end

    int   rise1 = 0;
    logic prev1 = 1'b0;
    always @(negedge clk_i) begin
        if (led_o[1] === 1'b1 && prev1 !== 1'b1) rise1++;
        prev1 = led_o[1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_c(input int x);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((cyc % CMAX) != x && n < 1000);
        if ((cyc % CMAX) != x) chk("wait_c timeout", cyc % CMAX, x);
    endtask

    task automatic pulse1;
        event_i[1] = 1'b1;
        @(negedge clk_i);
        event_i[1] = 1'b0;
    endtask

    initial begin
        int n, r0;
        repeat (3) @(negedge clk_i);
        chk_en = 1;
        chk("reset led_o", led_o, 0);
        chk("reset busy_o", busy_o, 0);
        reset_n_i = 1'b1;

        // steady on / off
        @(negedge clk_i);
        mode_i[1:0] = 2'b01;
        chk("on before edge", led_o[0], 0);
        @(negedge clk_i);
        chk("on after edge", led_o[0], 1);
        repeat (3) @(negedge clk_i);
        mode_i[1:0] = 2'b00;
        @(negedge clk_i);
        chk("off after edge", led_o[0], 0);

        // blink, slowest and fastest rate
        mode_i[1:0] = 2'b10;
        rate_i[1:0] = 2'd0;
        @(negedge clk_i);
        n = 0;
        repeat (256) begin @(negedge clk_i); n += int'(led_o[0]); end
        chk("blink r0 high count/256", n, 128);
        rate_i[1:0] = 2'd3;
        @(negedge clk_i);
        n = 0;
        repeat (64) begin @(negedge clk_i); n += int'(led_o[0]); end
        chk("blink r3 high count/64", n, 32);
        wait_c(16);
        chk("blink r3 c=15 delayed", led_o[0], 0);
        wait_c(17);
        chk("blink r3 c=16 delayed", led_o[0], 1);

        // single activity flash on ch1
        wait_c(0);
        mode_i[3:2] = 2'b11;
        wait_c(1);
        pulse1();
        wait_c(3);
        chk("act on led", led_o[1], 1);
        chk("act on busy", busy_o[1], 1);
        wait_c(12);
        chk("act last on led", led_o[1], 1);
        wait_c(13);
        chk("act gap led", led_o[1], 0);
        chk("act gap busy", busy_o[1], 1);
        wait_c(24);
        chk("act last gap busy", busy_o[1], 1);
        wait_c(25);
        chk("act idle busy", busy_o[1], 0);

        // events during ON and GAP yield exactly one re-trigger
        r0 = rise1;
        wait_c(40);
        pulse1();
        wait_c(45);
        pulse1();
        wait_c(55);
        pulse1();
        wait_c(64);
        chk("retrig gap end led", led_o[1], 0);
        wait_c(65);
        chk("retrig on led", led_o[1], 1);
        wait_c(88);
        chk("retrig last gap busy", busy_o[1], 1);
        wait_c(89);
        chk("retrig idle busy", busy_o[1], 0);
        wait_c(110);
        chk("retrig flash count", rise1 - r0, 2);

        // leaving activity mode mid-flash, events ignored outside it
        wait_c(130);
        pulse1();
        wait_c(135);
        chk("abort before led", led_o[1], 1);
        mode_i[3:2] = 2'b00;
        wait_c(136);
        chk("abort led", led_o[1], 0);
        chk("abort busy", busy_o[1], 0);
        wait_c(140);
        pulse1();
        wait_c(143);
        chk("ignored event busy", busy_o[1], 0);
        wait_c(150);
        mode_i[3:2] = 2'b11;
        wait_c(152);
        chk("reenter idle busy", busy_o[1], 0);

        // asynchronous reset mid-operation
        wait_c(160);
        mode_i[1:0] = 2'b01;
        pulse1();
        wait_c(163);
        chk("pre-reset led0", led_o[0], 1);
        chk("pre-reset busy1", busy_o[1], 1);
        #2 reset_n_i = 1'b0;
        #1;
        chk("async reset led_o", led_o, 0);
        chk("async reset busy_o", busy_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        mode_i = 4'b0010;
        rate_i = 4'b0011;
        wait_c(16);
        chk("post-reset phase c=15", led_o[0], 0);
        wait_c(17);
        chk("post-reset phase c=16", led_o[0], 1);

`ifdef LED_DRIVER_PWM_EN
        mode_i[1:0] = 2'b01;
        duty_i[7:0] = 8'd64;
        @(negedge clk_i);
        n = 0;
        repeat (256) begin @(negedge clk_i); n += int'(led_o[0]); end
        chk("pwm duty64 count", n, 64);
        duty_i[7:0] = 8'd0;
        @(negedge clk_i);
        n = 0;
        repeat (256) begin @(negedge clk_i); n += int'(led_o[0]); end
        chk("pwm duty0 count", n, 0);
        duty_i[7:0] = 8'hFF;
        @(negedge clk_i);
        n = 0;
        repeat (256) begin @(negedge clk_i); n += int'(led_o[0]); end
        chk("pwm duty255 count", n, 256);
`endif

        repeat (4) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
